word_gather: RTL
================

Name: word_gather

Overview:
- Serial-to-parallel word packer; the write-side counterpart of the packed-bus word selector.
- Accepts DAT_WIDTH-bit words one per handshake and places each into its slot of a packed TOTAL_DAT-bit bus.
- Presents the completed bus downstream with valid/ready.
- Sits between narrow streaming producers and wide consumers, for example ahead of the barrel shifter datapath.

Parameters:
- DAT_WIDTH, 16, bits per word.
- SEL_WIDTH, 3, slot index width.
- TOTAL_DAT, DAT_WIDTH << SEL_WIDTH, packed bus width (derived; do not override).
- NUM_WORDS, 1 << SEL_WIDTH, slots per group (derived; do not override).

Ports:
- clk  input  1  sole clock; all logic rising-edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  producer word valid.
- in_ready  output  1  block accepts word this cycle.
- in_data  input  DAT_WIDTH  word payload.
- in_last  input  1  with accepted word: close group early (partial group).
- out_valid  output  1  packed group available.
- out_ready  input  1  consumer accepts group.
- out_data  output  TOTAL_DAT  packed group; slot s at bits [s*DAT_WIDTH +: DAT_WIDTH].
- out_mask  output  NUM_WORDS  bit s set when slot s holds a word of this group.
- out_count  output  SEL_WIDTH+1  number of words in group, 1..NUM_WORDS.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_mask=0, out_count=0, fill count=0, state FILL, in_ready=1 on the first cycle after reset.
- Input handshake: a word is accepted when in_valid && in_ready. Output handshake: a group is consumed when out_valid && out_ready.
- State FILL:
  - in_ready=1, out_valid=0.
  - Each accepted word goes to slot cnt, sets mask bit cnt, then cnt increments.
  - When the word lands in slot NUM_WORDS-1, or in_last=1, go to HOLD on the next edge with out_count=cnt+1 and cnt cleared.
- State HOLD:
  - out_valid=1; out_data, out_mask and out_count are stable until consumed.
  - in_ready = out_ready, giving a pass-through on the drain cycle with no bubble.
  - If the group is consumed and no word is accepted: return to FILL with data and mask cleared.
  - If the group is consumed and a word is accepted in the same cycle: the new word goes to slot 0 of a fresh group. Data and mask are cleared, then slot 0 and mask bit 0 are written, cnt=1, state FILL.
    - If that word also has in_last=1, or NUM_WORDS=1, stay in HOLD with out_count=1.
- Latency: out_valid rises on the cycle after the group-closing word is accepted.
- Throughput: one word per cycle sustained when out_ready is held at 1.
- Unused slots of a partial group read as zero.
- in_last on the NUM_WORDS-th word behaves the same as a full group.
- in_valid is ignored when in_ready=0. Producer data is not sampled.
- rst asserted mid-group discards the partial group. rst overrides all handshakes in that cycle.
- cnt is SEL_WIDTH+1 bits wide and never exceeds NUM_WORDS-1 in FILL.
- Degenerate case SEL_WIDTH=0: every accepted word closes the group.

Optional Feature:
- Macro: WORD_GATHER_ROTATE_EN.
- When defined:
  - Adds input port in_base, width SEL_WIDTH.
  - in_base is sampled on the first word of each group and held for the rest of that group.
  - Word k of the group lands in slot (base+k) mod NUM_WORDS, wrapping modulo NUM_WORDS. out_mask follows the same rotated slots.
  - Group-close and out_count rules are unchanged.
  - in_base values presented on later words of a group are ignored.
- When undefined: base is fixed at 0, the port is absent, and behaviour is exactly as above.

Decomposition:
- Package word_gather_pkg:
  - State enum {FILL, HOLD}.
  - Default DAT_WIDTH and SEL_WIDTH constants.
  - Function computing slot = (base+k) mod NUM_WORDS.
- Sub-module word_gather_slot_dec: SEL_WIDTH-bit index plus enable in, NUM_WORDS one-hot write strobe out.
  - Used for both the data-slot write and the mask update.

Test Plan (DAT_WIDTH=16, SEL_WIDTH=2):
1. Full group, out_ready=1: words 0x1111, 0x2222, 0x3333, 0x4444 on 4 consecutive cycles → next cycle out_valid=1, out_data=0x4444_3333_2222_1111, out_mask=4'b1111, out_count=4.
2. Partial group: 0xAAAA, then 0xBBBB with in_last=1 → out_data=0x0000_0000_BBBB_AAAA, out_mask=4'b0011, out_count=2.
3. Backpressure then pass-through: out_ready=0 for 5 cycles → in_ready=0 and outputs stable. Raise out_ready with in_valid=1 and data 0x5555 → old group consumed, new group slot 0=0x5555, no bubble.
4. Reset mid-group: accept 2 words, pulse rst 1 cycle → out_valid=0, outputs 0. Next 4 words form a clean group with mask 4'b1111.
5. Streaming: 12 words back-to-back with out_ready=1 → 3 groups, no lost or duplicated word, in_ready never drops.
6. With WORD_GATHER_ROTATE_EN, in_base=3: words 0x1, 0x2, 0x3 with in_last on 0x3 → slots 3, 0, 1. out_data=0x0001_0000_0003_0002, out_mask=4'b1011, out_count=3.

Source files
------------

// File: rtl/word_gather_pkg.sv
// word_gather_pkg: shared types, default widths and slot arithmetic for word_gather
// Contents:
//    state_t        FILL collects words, HOLD presents a finished group
//    DEF_DAT_WIDTH  default bits per word
//    DEF_SEL_WIDTH  default slot index width
//    slot_idx()     slot = (base + k) mod num_words
package word_gather_pkg;
   typedef enum logic {FILL, HOLD} state_t;
   localparam int DEF_DAT_WIDTH = 16;
   localparam int DEF_SEL_WIDTH = 3;
   function automatic int unsigned slot_idx(input int unsigned base, input int unsigned k, input int unsigned num_words);
      return (base + k) % num_words;
   endfunction
endpackage

// File: rtl/word_gather_slot_dec.sv
// word_gather_slot_dec: slot index to one-hot write strobe
// Ports:
//    i_idx   slot index
//    i_en    strobe enable
//    o_strb  one-hot strobe, all zero when i_en is low
module word_gather_slot_dec #(
   parameter int SEL_WIDTH = 3,
   localparam int NUM_WORDS = 1 << SEL_WIDTH
) (
   input  logic [SEL_WIDTH-1:0] i_idx,
   input  logic                 i_en,
   output logic [NUM_WORDS-1:0] o_strb
);
   assign o_strb = i_en ? NUM_WORDS'(1) << i_idx : '0;
endmodule

// File: rtl/word_gather.sv
// word_gather: serial-to-parallel packer, DAT_WIDTH words into a TOTAL_DAT bus
// Ports:
//    clk, rst               rising-edge clock, synchronous active-high reset
//    in_valid/in_ready      producer word handshake, in_data payload
//    in_last                closes the group early with the accepted word
//    in_base                first slot of a group (only with WORD_GATHER_ROTATE_EN)
//    out_valid/out_ready    consumer group handshake
//    out_data               packed group, slot s at [s*DAT_WIDTH +: DAT_WIDTH]
//    out_mask               slots holding a word of this group
//    out_count              words in the group, 1..NUM_WORDS
// Build option: define WORD_GATHER_ROTATE_EN to rotate slot placement by in_base.
module word_gather
   import word_gather_pkg::*;
#(
   parameter int DAT_WIDTH = DEF_DAT_WIDTH,
   parameter int SEL_WIDTH = DEF_SEL_WIDTH,
   localparam int TOTAL_DAT = DAT_WIDTH << SEL_WIDTH,
   localparam int NUM_WORDS = 1 << SEL_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef WORD_GATHER_ROTATE_EN
   input  logic [SEL_WIDTH-1:0] in_base,
`endif
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DAT_WIDTH-1:0] in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [TOTAL_DAT-1:0] out_data,
   output logic [NUM_WORDS-1:0] out_mask,
   output logic [SEL_WIDTH:0]   out_count
);
   state_t               r_state;
   logic [SEL_WIDTH:0]   r_cnt;
   logic [SEL_WIDTH:0]   r_count;
   logic [TOTAL_DAT-1:0] r_data;
   logic [NUM_WORDS-1:0] r_mask;
   logic                 w_hold;
   logic                 w_acc;
   logic                 w_cons;
   logic                 w_close;
   logic [SEL_WIDTH:0]   w_k;
   logic [SEL_WIDTH-1:0] w_base;
   logic [SEL_WIDTH-1:0] w_slot;
   logic [NUM_WORDS-1:0] w_strb;
   logic [NUM_WORDS-1:0] w_mask_nx;
   logic [TOTAL_DAT-1:0] w_data_nx;
   assign w_hold    = r_state == HOLD;
   assign in_ready  = !w_hold || out_ready;
   assign out_valid = w_hold;
   assign out_data  = r_data;
   assign out_mask  = r_mask;
   assign out_count = r_count;
   assign w_acc     = in_valid && in_ready;
   assign w_cons    = w_hold && out_ready;
   // a word accepted in HOLD is always the first word of a fresh group
   assign w_k       = w_hold ? '0 : r_cnt;
   assign w_close   = w_acc && (in_last || w_k == (SEL_WIDTH+1)'(NUM_WORDS - 1));
`ifdef WORD_GATHER_ROTATE_EN
   logic [SEL_WIDTH-1:0] r_base;
   assign w_base = (w_k == '0) ? in_base : r_base;
   always_ff @(posedge clk) begin
      if (rst) r_base <= '0;
      else if (w_acc) r_base <= w_base;
   end
`else
   assign w_base = '0;
`endif
   assign w_slot = SEL_WIDTH'(slot_idx(32'(w_base), 32'(w_k), NUM_WORDS));
   word_gather_slot_dec #(.SEL_WIDTH(SEL_WIDTH)) u_dec (
      .i_idx (w_slot),
      .i_en  (w_acc),
      .o_strb(w_strb)
   );
   // on a drain cycle the next group starts from an empty bus
   assign w_mask_nx = (w_hold ? '0 : r_mask) | w_strb;
   for (genvar g = 0; g < NUM_WORDS; g++) begin : g_slot
      assign w_data_nx[g*DAT_WIDTH +: DAT_WIDTH] = w_strb[g] ? in_data : (w_hold ? '0 : r_data[g*DAT_WIDTH +: DAT_WIDTH]);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= FILL;
         r_cnt   <= '0;
         r_count <= '0;
         r_data  <= '0;
         r_mask  <= '0;
      end else if (!w_hold || w_cons) begin
         r_state <= w_close ? HOLD : FILL;
         r_cnt   <= w_close ? '0 : w_k + (SEL_WIDTH+1)'(w_acc);
         r_count <= w_close ? w_k + 1'b1 : (w_hold ? '0 : r_count);
         r_data  <= w_data_nx;
         r_mask  <= w_mask_nx;
      end
   end
endmodule
